// File: rtl/bk_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder/subtractor.
package bk_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Default geometry; each module derives its own from its parameters.
    localparam int DFLT_WIDTH     = 32;
    localparam int DFLT_GROUPSIZE = 4;
    localparam int DFLT_NGROUPS   = DFLT_WIDTH / DFLT_GROUPSIZE;
    localparam int DFLT_LEVELS    = clog2(DFLT_NGROUPS);

    // Group generate/propagate pair.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix combine: hi covers the more significant span, lo the less.
    function automatic gp_t gp_op(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung prefix over group (G,P) pairs.
// pfx_o[i] is the combined (G,P) of groups i..0.
module bk_prefix_tree import bk_pkg::*; #(
    parameter int NGROUPS = 8
) (
    input  gp_t [NGROUPS-1:0] gp_i,
    output gp_t [NGROUPS-1:0] pfx_o
);
    localparam int LEVELS = clog2(NGROUPS);

    // Up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin : sweep
        gp_t t [NGROUPS];
        for (int i = 0; i < NGROUPS; i++) t[i] = gp_i[i];
        for (int l = 0; l < LEVELS; l++)
            for (int i = (2 << l) - 1; i < NGROUPS; i += (2 << l))
                t[i] = gp_op(t[i], t[i - (1 << l)]);
        for (int l = LEVELS - 2; l >= 0; l--)
            for (int i = (3 << l) - 1; i < NGROUPS; i += (2 << l))
                t[i] = gp_op(t[i], t[i - (1 << l)]);
        pfx_o = '0;
        for (int i = 0; i < NGROUPS; i++) pfx_o[i] = t[i];
    end

endmodule

// File: rtl/bk_addsub_pipe.sv
// Three-stage Brent-Kung adder/subtractor with valid/ready back-pressure.
// Stage 1: group G/P, stage 2: group carry-ins, stage 3: sums and flags.
module bk_addsub_pipe import bk_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NGROUPS = WIDTH / GROUPSIZE;
    localparam int MSB     = WIDTH - 1;

    logic [3:1] vld_q;
    logic       rdy1, rdy2, rdy3;

    // A stage is free if empty or if its content moves on this cycle.
    assign rdy3     = ~vld_q[3] | out_ready;
    assign rdy2     = ~vld_q[2] | rdy3;
    assign rdy1     = ~vld_q[1] | rdy2;
    assign in_ready = rdy1;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0]   b_eff;
    logic               c0;
    gp_t [NGROUPS-1:0]  gp_d;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub | in_cin;

    // Per-group generate/propagate, rippled across GROUPSIZE bits.
    always_comb begin : grp_gp
        logic gg, pp;
        int   idx;
        gp_d = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j < GROUPSIZE; j++) begin
                idx = g * GROUPSIZE + j;
                gg  = (in_a[idx] & b_eff[idx]) | ((in_a[idx] ^ b_eff[idx]) & gg);
                pp  = pp & (in_a[idx] ^ b_eff[idx]);
            end
            gp_d[g].g = gg;
            gp_d[g].p = pp;
        end
    end

    logic [WIDTH-1:0]  s1_a_q, s1_b_q;
    logic              s1_c0_q;
    logic [TAG_W-1:0]  s1_tag_q;
    gp_t [NGROUPS-1:0] s1_gp_q;

    // Stage 1 register: loads on an accepted input, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q[1] <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_c0_q  <= 1'b0;
            s1_tag_q <= '0;
            s1_gp_q  <= '0;
        end else begin
            if (rdy1) vld_q[1] <= in_valid;
            if (in_valid && rdy1) begin
                s1_a_q   <= in_a;
                s1_b_q   <= b_eff;
                s1_c0_q  <= c0;
                s1_tag_q <= in_tag;
                s1_gp_q  <= gp_d;
            end
        end
    end

    // ---------------- stage 2 ----------------
    gp_t [NGROUPS-1:0] pfx;
    logic [NGROUPS:0]  cin_d;

    bk_prefix_tree #(.NGROUPS(NGROUPS)) u_tree (
        .gp_i  (s1_gp_q),
        .pfx_o (pfx)
    );

    // Carry into group i; entry NGROUPS is the carry out of the MSB group.
    always_comb begin
        cin_d    = '0;
        cin_d[0] = s1_c0_q;
        for (int i = 1; i <= NGROUPS; i++)
            cin_d[i] = pfx[i-1].g | (pfx[i-1].p & s1_c0_q);
    end

    logic [WIDTH-1:0] s2_a_q, s2_b_q;
    logic [NGROUPS:0] s2_c_q;
    logic [TAG_W-1:0] s2_tag_q;

    // Stage 2 register: operands plus resolved group carries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q[2] <= 1'b0;
            s2_a_q   <= '0;
            s2_b_q   <= '0;
            s2_c_q   <= '0;
            s2_tag_q <= '0;
        end else begin
            if (rdy2) vld_q[2] <= vld_q[1];
            if (vld_q[1] && rdy2) begin
                s2_a_q   <= s1_a_q;
                s2_b_q   <= s1_b_q;
                s2_c_q   <= cin_d;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    // ---------------- stage 3 ----------------
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d, zero_d;

    // Per-group ripple sum seeded by the group carry-in, then flags.
    always_comb begin : grp_sum
        logic c;
        int   idx;
        sum_d = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            c = s2_c_q[g];
            for (int j = 0; j < GROUPSIZE; j++) begin
                idx        = g * GROUPSIZE + j;
                sum_d[idx] = s2_a_q[idx] ^ s2_b_q[idx] ^ c;
                c          = (s2_a_q[idx] & s2_b_q[idx]) | (c & (s2_a_q[idx] ^ s2_b_q[idx]));
            end
        end
        ovf_d  = (s2_a_q[MSB] == s2_b_q[MSB]) & (sum_d[MSB] != s2_a_q[MSB]);
        zero_d = ~|sum_d;
    end

    logic [WIDTH-1:0] s3_sum_q;
    logic             s3_cout_q, s3_ovf_q, s3_zero_q;
    logic [TAG_W-1:0] s3_tag_q;

    // Output register: held stable while stalled by out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q[3]  <= 1'b0;
            s3_sum_q  <= '0;
            s3_cout_q <= 1'b0;
            s3_ovf_q  <= 1'b0;
            s3_zero_q <= 1'b0;
            s3_tag_q  <= '0;
        end else begin
            if (rdy3) vld_q[3] <= vld_q[2];
            if (vld_q[2] && rdy3) begin
                s3_sum_q  <= sum_d;
                s3_cout_q <= s2_c_q[NGROUPS];
                s3_ovf_q  <= ovf_d;
                s3_zero_q <= zero_d;
                s3_tag_q  <= s2_tag_q;
            end
        end
    end

    assign out_valid = vld_q[3];
    assign out_sum   = s3_sum_q;
    assign out_cout  = s3_cout_q;
    assign out_ovf   = s3_ovf_q;
    assign out_zero  = s3_zero_q;
    assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_bk_addsub_pipe.sv
// Bench for bk_addsub_pipe: directed checks on a 32/4 instance, and
// randomized streams against an arithmetic model on 8/2, 16/4, 64/8, 32/4.
module tb_bk_addsub_pipe;
    localparam int TW   = 4;
    localparam int NOPS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int ndone = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed instance (32/4) ----------------
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic [31:0]   in_a = '0, in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, out_valid, out_cout, out_ovf, out_zero;
    logic [31:0]   out_sum;
    logic [TW-1:0] out_tag;

    bk_addsub_pipe #(.WIDTH(32), .GROUPSIZE(4), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    task automatic put(input int t);
        in_a     = 32'(t * 100);
        in_b     = 32'(t);
        in_tag   = TW'(t);
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        in_valid = 1'b1;
    endtask

    // One isolated op: checks exact 3-cycle latency and literal results.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [TW-1:0] tag,
                          input logic [31:0] esum, input logic ecout, input logic eovf,
                          input logic ezero);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        chk("idle_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        tick(); chk("lat2_valid", out_valid, 0);
        tick(); chk("lat3_valid", out_valid, 1);
        chk("sum", out_sum, esum);
        chk("cout", out_cout, ecout);
        chk("ovf", out_ovf, eovf);
        chk("zero", out_zero, ezero);
        chk("tag", out_tag, tag);
        tick(); chk("drained", out_valid, 0);
    endtask

    initial begin : main
        int acc, nxt;
        logic take;
        logic [31:0] snap;

        // reset / idle
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);

        // literal arithmetic
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd5, 32'h0, 1'b1, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'd6, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(32'd3, 32'd5, 1'b0, 1'b1, 4'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 4'd8, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(32'd5, 32'd5, 1'b1, 1'b1, 4'd9, 32'h0, 1'b1, 1'b0, 1'b1);

        // back-pressure: 5 ops into a stalled pipe
        out_ready = 1'b0; nxt = 1; acc = 0; put(1);
        for (int c = 0; c < 7; c++) begin
            take = in_valid && in_ready;
            if (take) acc++;
            tick();
            if (take) begin
                if (nxt < 5) begin nxt++; put(nxt); end
                else in_valid = 1'b0;
            end
        end
        chk("bp_accepts", acc, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_tag", out_tag, 1);
        snap = out_sum;
        tick(); tick();
        chk("bp_stable_sum", out_sum, snap);
        chk("bp_stable_tag", out_tag, 1);
        chk("bp_sum1", out_sum, 101);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_tag", out_tag, k);
            chk("bp_drain_sum", out_sum, 101 * k);
            take = in_valid && in_ready;
            if (take) acc++;
            tick();
            if (take) begin
                if (nxt < 5) begin nxt++; put(nxt); end
                else in_valid = 1'b0;
            end
        end
        chk("bp_no_dup", out_valid, 0);
        chk("bp_total", acc, 5);

        // mid-stream reset
        out_ready = 1'b0; nxt = 7; acc = 0; put(7);
        for (int c = 0; c < 3; c++) begin
            take = in_valid && in_ready;
            if (take) acc++;
            tick();
            if (take) begin
                if (nxt < 9) begin nxt++; put(nxt); end
                else in_valid = 1'b0;
            end
        end
        chk("mr_accepts", acc, 3);
        chk("mr_full_valid", out_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_sum", out_sum, 0);
        chk("mr_tag", out_tag, 0);
        chk("mr_in_ready", in_ready, 1);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("mr_no_stale", out_valid, 0);
        end

        // wait for the random sweeps, bounded
        for (int i = 0; i < 70000 && ndone < 4; i++) @(negedge clk);
        chk("sweeps_finished", ndone, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    // ---------------- randomized sweeps ----------------
    logic rst_sw_n = 1'b0;
    initial begin
        repeat (3) @(negedge clk);
        rst_sw_n = 1'b1;
    end

    for (genvar k = 0; k < 4; k++) begin : g_sw
        localparam int W  = (k == 0) ? 8 : (k == 1) ? 16 : (k == 2) ? 64 : 32;
        localparam int GS = (k == 0) ? 2 : (k == 1) ? 4  : (k == 2) ? 8  : 4;
        typedef logic [TW+W+1:0] exp_t;

        logic          iv, ir, icin, isub, ov, ordy, ocout, oovf, ozero;
        logic [W-1:0]  ia, ib, osum;
        logic [TW-1:0] itag, otag;
        exp_t          q[$];

        bk_addsub_pipe #(.WIDTH(W), .GROUPSIZE(GS), .TAG_W(TW)) u_dut (
            .clk(clk), .rst_n(rst_sw_n),
            .in_valid(iv), .in_ready(ir),
            .in_a(ia), .in_b(ib), .in_cin(icin), .in_sub(isub), .in_tag(itag),
            .out_valid(ov), .out_ready(ordy),
            .out_sum(osum), .out_cout(ocout), .out_ovf(oovf),
            .out_zero(ozero), .out_tag(otag)
        );

        // Plain arithmetic: returns {ovf, cout, sum}.
        function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sub);
            logic [W:0] u, r;
            logic       co;
            if (sub) begin
                u  = {1'b0, a} - {1'b0, b};
                co = (a >= b);
                r  = {a[W-1], a} - {b[W-1], b};
            end else begin
                u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                co = u[W];
                r  = {a[W-1], a} + {b[W-1], b} + {{W{1'b0}}, cin};
            end
            return {r[W] ^ r[W-1], co, u[W-1:0]};
        endfunction

        function automatic logic [W-1:0] rnd();
            logic [63:0] r;
            logic [W-1:0] v;
            r = {$urandom, $urandom};
            v = r[W-1:0];
            case ($urandom_range(0, 9))
                0: v = '0;
                1: v = '1;
                2: v = {1'b1, {(W-1){1'b0}}};
                3: v = {1'b0, {(W-1){1'b1}}};
                default: ;
            endcase
            return v;
        endfunction

        initial begin : run
            exp_t          e;
            logic          take, stall;
            logic [W+TW+3:0] snap;
            logic [W-1:0]  ones, one, minv;
            int            cyc, got;
            string         pfx;

            pfx = $sformatf("w%0d_", W);
            iv = 1'b0; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0; itag = '0; ordy = 1'b0;
            ones = '1; one = W'(1); minv = {1'b1, {(W-1){1'b0}}};

            // pin the model with hand-derived values
            chk({pfx, "pin_wrap"}, model(ones, one, 1'b0, 1'b0), {1'b0, 1'b1, {W{1'b0}}});
            chk({pfx, "pin_subovf"}, model(minv, one, 1'b0, 1'b1), {1'b1, 1'b1, ~minv});
            chk({pfx, "pin_borrow"}, model(one, ones, 1'b1, 1'b1), {1'b0, 1'b0, W'(2)});

            repeat (5) @(negedge clk);
            take = 1'b0; stall = 1'b0; snap = '0; cyc = 0; got = 0;
            while (got < NOPS && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                ordy = ($urandom_range(0, 9) < 7);
                if (take || !iv) begin
                    iv   = ($urandom_range(0, 9) < 8);
                    ia   = rnd();
                    ib   = rnd();
                    icin = 1'($urandom_range(0, 1));
                    isub = 1'($urandom_range(0, 1));
                    itag = TW'($urandom);
                end
                #1;
                chk({pfx, "in_ready"}, ir, (q.size() < 3) || ordy);
                if (stall) chk({pfx, "stall_stable"}, {ov, otag, oovf, ocout, ozero, osum}, snap);
                if (ov && q.size() == 0) begin
                    chk({pfx, "spurious_valid"}, ov, 0);
                end else if (ov && ordy) begin
                    e = q.pop_front();
                    chk({pfx, "sum"}, osum, e[W-1:0]);
                    chk({pfx, "cout"}, ocout, e[W]);
                    chk({pfx, "ovf"}, oovf, e[W+1]);
                    chk({pfx, "zero"}, ozero, e[W-1:0] == '0);
                    chk({pfx, "tag"}, otag, e[TW+W+1:W+2]);
                    got++;
                end
                stall = ov && !ordy;
                snap  = {ov, otag, oovf, ocout, ozero, osum};
                take  = iv && ir;
                if (take) q.push_back({itag, model(ia, ib, icin, isub)});
            end
            chk({pfx, "ops_completed"}, got, NOPS);
            ndone++;
        end
    end

endmodule
